// File: rtl/divu_pkg.sv
// Shared definitions for the divu restoring divider: default width,
// FSM state type and counter sizing.
package divu_pkg;

    localparam int unsigned DIVU_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divu_state_t;

    function automatic int unsigned divu_cnt_bits(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/divu_if.sv
// Start/busy/done handshake and operand/result bus between the core and divu.
interface divu_if
    import divu_pkg::*;
#(
    parameter int unsigned WIDTH = DIVU_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;

    modport master (
        output start, a, b,
        input  busy, done, q, r, dz
    );

    modport slave (
        input  start, a, b,
        output busy, done, q, r, dz
    );
endinterface

// File: rtl/divu_step.sv
// One restoring-division iteration: trial subtract of the divisor from the
// shifted partial remainder, restoring on borrow.
module divu_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH:0]   rem,
    input  logic             shift_bit,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH:0]   rem_new,
    output logic             q_bit
);
    logic [WIDTH+1:0] trial;

    // Guard bit of rem is always 0 between steps, so widening the trial by it
    // is equivalent to subtracting from {rem[WIDTH-1:0], shift_bit}.
    always_comb begin
        trial   = {rem, shift_bit} - {2'b00, div};
        q_bit   = ~trial[WIDTH+1];
        rem_new = q_bit ? trial[WIDTH:0] : {rem[WIDTH-1:0], shift_bit};
    end
endmodule

// File: rtl/divu.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake and divide-by-zero flag.
module divu
    import divu_pkg::*;
#(
    parameter int unsigned WIDTH = DIVU_WIDTH
) (
    input  logic  clk,
    input  logic  reset_n,
    divu_if.slave bus
);
    localparam int unsigned CW = divu_cnt_bits(WIDTH);

    divu_state_t      state;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] div;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   rem_new;
    logic             q_bit;
    logic [WIDTH-1:0] quo_new;

    divu_step #(.WIDTH(WIDTH)) u_step (
        .rem       (rem),
        .shift_bit (quo[WIDTH-1]),
        .div       (div),
        .rem_new   (rem_new),
        .q_bit     (q_bit)
    );

    assign quo_new = {quo[WIDTH-2:0], q_bit};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rem      <= '0;
            quo      <= '0;
            div      <= '0;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.q    <= '0;
            bus.r    <= '0;
            bus.dz   <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        if (bus.b != '0) begin
                            quo      <= bus.a;
                            div      <= bus.b;
                            rem      <= '0;
                            cnt      <= CW'(WIDTH);
                            bus.busy <= 1'b1;
                            state    <= BUSY;
                        end else begin
                            bus.q    <= '1;
                            bus.r    <= bus.a;
                            bus.dz   <= 1'b1;
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    rem <= rem_new;
                    quo <= quo_new;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        bus.q    <= quo_new;
                        bus.r    <= rem_new[WIDTH-1:0];
                        bus.dz   <= 1'b0;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
